pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 10 +
 rtl/adder_slice.sv | 30 +++
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and stage-count helper for the pipelined adder
package adder_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE_W = 16;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int nstage(input int width, input int slice_w);
    return width / slice_w;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SLICE_W-bit add/subtract slice with carry chain
// Ports: a_s/b_s operand slices, cin carry in, sub (OP_SUB inverts b_s),
//        s slice sum, cout carry out; cmsb (carry into the slice MSB) only
//        exists when PIPELINED_ADDER_OVF_EN is defined.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic [SLICE_W-1:0] a_s,
  input  logic [SLICE_W-1:0] b_s,
  input  logic               cin,
  input  logic               sub,
  output logic [SLICE_W-1:0] s,
  output logic               cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic               cmsb
`endif
);
  logic [SLICE_W-1:0] bx;
  always_comb begin
    bx = (sub == OP_ADD) ? b_s : ~b_s;
    {cout, s} = {1'b0, a_s} + {1'b0, bx} + (SLICE_W + 1)'(cin);
  end
`ifdef PIPELINED_ADDER_OVF_EN
  // a ^ b ^ sum at a bit position recovers the carry that entered it
  assign cmsb = a_s[SLICE_W-1] ^ bx[SLICE_W-1] ^ s[SLICE_W-1];
`endif
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into WIDTH/SLICE_W carry-chained register stages
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, sub, carry_in on the input side;
//        out_valid/out_ready + sum, carry_out on the output side.
// Optional: define PIPELINED_ADDER_OVF_EN to add the ovf output (signed overflow, pipelined with sum).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSTAGE = nstage(WIDTH, SLICE_W);
  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of SLICE_W");
  end
  logic adv;
  logic v_q[NSTAGE], c_q[NSTAGE], sub_q[NSTAGE];
  logic [WIDTH-1:0] a_q[NSTAGE], b_q[NSTAGE], s_q[NSTAGE];
  logic v_src[NSTAGE], c_src[NSTAGE], sub_src[NSTAGE], co[NSTAGE];
  logic [WIDTH-1:0] a_src[NSTAGE], b_src[NSTAGE], s_src[NSTAGE];
  logic [SLICE_W-1:0] ls[NSTAGE];
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_valid = v_q[NSTAGE-1];
  assign sum = s_q[NSTAGE-1];
  assign carry_out = c_q[NSTAGE-1];
  // stage k consumes the registers of stage k-1; stage 0 consumes the ports
  always_comb begin
    v_src[0] = in_valid;
    c_src[0] = carry_in;
    sub_src[0] = sub;
    a_src[0] = a;
    b_src[0] = b;
    s_src[0] = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      sub_src[k] = sub_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
    end
  end
`ifdef PIPELINED_ADDER_OVF_EN
  logic cm[NSTAGE];
  logic ovf_q;
`endif
  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    adder_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a_s (a_src[k][k*SLICE_W +: SLICE_W]),
      .b_s (b_src[k][k*SLICE_W +: SLICE_W]),
      .cin (c_src[k]),
      .sub (sub_src[k]),
      .s   (ls[k]),
      .cout(co[k])
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .cmsb(cm[k])
`endif
    );
  end
  // upper sum slices are still zero when stage k runs, so OR-ing inserts slice k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        sub_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k] <= v_src[k];
        c_q[k] <= co[k];
        sub_q[k] <= sub_src[k];
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_src[k] | (WIDTH'(ls[k]) << (k * SLICE_W));
      end
    end
  end
`ifdef PIPELINED_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= cm[NSTAGE-1] ^ co[NSTAGE-1];
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized scoreboard bench for pipelined_adder against an arithmetic model
module tb_pipelined_adder;
  import adder_pkg::*;
  localparam int W = 64;
  localparam int SW = 16;
  localparam int NS = W / SW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic sub = 1'b0;
  logic carry_in = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] sum;
  logic carry_out;
`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf;
`endif
  typedef struct {
    logic [W:0] res;
    logic       ov;
    time        t;
    bit         lat;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  bit rnd_done = 0;

  pipelined_adder #(.WIDTH(W), .SLICE_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c);
    exp_t e;
    logic [W-1:0] yb;
    yb = (s == OP_SUB) ? ~y : y;
    e.res = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, c};
    e.ov = (x[W-1] == yb[W-1]) && (e.res[W-1] != x[W-1]);
    e.t = 0;
    e.lat = 0;
    return e;
  endfunction

  // drives one operand set and waits (bounded) for the edge that accepts it
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c, input bit lat);
    exp_t e;
    bit acc;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    carry_in = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        e = model(x, y, s, c);
        e.t = $time;
        e.lat = lat;
        q.push_back(e);
        #2;
        in_valid = 1'b0;
        return;
      end
      #2;
    end
    n_chk++;
    n_fail++;
    $display("FAIL accept_timeout: in_ready never rose for a=%0h", x);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain_empty", q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got sum %0h with no pending transaction", sum);
        end else if (!out_ready) begin
          check("stall_hold", {carry_out, sum}, q[0].res);
        end else begin
          e = q.pop_front();
          check("result", {carry_out, sum}, e.res);
`ifdef PIPELINED_ADDER_OVF_EN
          check("ovf", ovf, e.ov);
`endif
          if (e.lat) check("latency", int'(($time - 5 - e.t) / 10), NS - 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_carry", carry_out, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    send(64'd1245634, 64'd87903422, OP_ADD, 1'b1, 1);
    send(64'd9999, 64'd2222, OP_ADD, 1'b0, 1);
    send(64'd8691649, 64'd2, OP_ADD, 1'b1, 1);
    send(64'd90909, 64'd6452748058, OP_ADD, 1'b0, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, OP_ADD, 1'b1, 1);
    send(64'h0000_0000_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, 1);
    send(64'd10, 64'd3, OP_SUB, 1'b1, 1);
    send(64'd3, 64'd10, OP_SUB, 1'b1, 1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, 1);
    send(64'd5, 64'd6, OP_ADD, 1'b0, 1);
    send(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 1'b1, 1);
    drain();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({$urandom(), $urandom()}, {$urandom(), $urandom()}, OP_ADD, 1'($urandom_range(0, 1)), 0);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, !out_valid);
        end
        check("stall_out_valid", out_valid, 1);
        check("stall_capacity", q.size(), NS);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    send(64'd100, 64'd200, OP_ADD, 1'b0, 0);
    send(64'd300, 64'd400, OP_ADD, 1'b1, 0);
    send(64'd500, 64'd600, OP_ADD, 1'b0, 0);
    idle(3);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_sum", sum, 0);
    check("midreset_carry", carry_out, 0);
    check("midreset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    send(64'd5, 64'd6, OP_ADD, 1'b0, 1);
    drain();
    for (int i = 0; i < 20; i++)
      send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    drain();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 2));
          send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
